// File: rtl/mod_classifier_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mod_classifier_pkg
//  Purpose  : Shared encodings for the modulation classifier: modulation type
//             codes, classifier FSM state encodings, the averaging block size
//             and the candidate priority function.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mod_classifier_pkg;

   // Modulation type codes, as presented on mod_type
   localparam logic [2:0] MOD_NONE    = 3'd0;
   localparam logic [2:0] MOD_CW      = 3'd1;
   localparam logic [2:0] MOD_AM      = 3'd2;
   localparam logic [2:0] MOD_FM      = 3'd3;
   localparam logic [2:0] MOD_DIGITAL = 3'd4;

   // Classifier FSM state encodings
   localparam logic [1:0] ST_SETTLE  = 2'd0;
   localparam logic [1:0] ST_CONFIRM = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   // Frequency averaging block: 2**AVG_LOG2 strobes per block
   localparam int AVG_LOG2 = 3;

   // Candidate priority: low amplitude masks everything, a square wave is
   // digital regardless of the AM/FM metrics, AM depth beats FM deviation.
   function automatic logic [2:0] classify(
      input logic i_low_vpp,
      input logic i_sine,
      input logic i_ma_hit,
      input logic i_foff_hit
   );
      logic [2:0] w_cls;
      if (i_low_vpp)       w_cls = MOD_NONE;
      else if (!i_sine)    w_cls = MOD_DIGITAL;
      else if (i_ma_hit)   w_cls = MOD_AM;
      else if (i_foff_hit) w_cls = MOD_FM;
      else                 w_cls = MOD_CW;
      return w_cls;
   endfunction

endpackage : mod_classifier_pkg
`default_nettype wire

// File: rtl/mod_classifier_freq_avg.sv
`default_nettype none
// ============================================================================
//  Module   : freq_block_avg
//  Purpose  : Block average of the measured frequency over 8 sample strobes.
//             A 19-bit accumulator holds up to 8 full-scale 16-bit samples
//             exactly, so the mean is a plain 3-bit right shift.
//  Ports    : clk, rst_n     clock / async active-low reset
//             i_strobe       sample strobe, one sample per pulse
//             i_clear        sync clear of the partial block (output held)
//             i_freq [15:0]  frequency sample
//             o_freq_avg[15:0] mean of the last complete block
//  Revision : 1.0  initial release
// ============================================================================
module freq_block_avg
   import mod_classifier_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_strobe,
   input  logic        i_clear,
   input  logic [15:0] i_freq,
   output logic [15:0] o_freq_avg
);

   localparam int ACC_W = 16 + AVG_LOG2;

   logic [ACC_W-1:0]    r_acc;
   logic [AVG_LOG2-1:0] r_cnt;
   logic [15:0]         r_avg;
   logic [ACC_W-1:0]    w_sum;

   // Running sum including the current sample; on the last strobe of a
   // block this is the full block total.
   assign w_sum = r_acc + {{AVG_LOG2{1'b0}}, i_freq};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_avg <= '0;
      end else if (i_clear) begin
         // Partial block discarded; the last published average stays.
         r_acc <= '0;
         r_cnt <= '0;
      end else if (i_strobe) begin
         if (r_cnt == {AVG_LOG2{1'b1}}) begin
            r_avg <= w_sum[ACC_W-1:AVG_LOG2];
            r_acc <= '0;
            r_cnt <= '0;
         end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_freq_avg = r_avg;

endmodule : freq_block_avg
`default_nettype wire

// File: rtl/mod_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : mod_classifier
//  Purpose  : Classifies the modulation of the measured signal as
//             NONE/CW/AM/FM/DIGITAL, debounces the decision with a
//             settle/confirm/lock FSM, block-averages frequency and drives
//             the ma/mf measurement enables back to the measurement stage.
//  Ports    : clk, rst_n            clock / async active-low reset
//             sample_en            one-clk sample strobe
//             restart              sync pulse: drop lock, re-settle
//             is_sine_wave         1 = sine, 0 = square
//             freq_out [15:0]      measured frequency
//             vpp [N-1:0]          peak-to-peak amplitude
//             ma [7:0], mf [7:0]   AM depth / FM index
//             f_offset_max [12:0]  max frequency deviation
//             mod_type [2:0]       locked modulation type
//             mod_valid            high while locked
//             freq_avg [15:0]      mean of the last 8-strobe block
//             ma_out, mf_out [7:0] ma/mf captured at lock / relock
//             ma_measure_enable    upstream ma enable
//             mf_measure_enable    upstream mf enable
//  Revision : 1.0  initial release
// ============================================================================
module mod_classifier
   import mod_classifier_pkg::*;
#(
   parameter int              N          = 8,
   parameter int              SETTLE_CNT = 400,
   parameter int              STABLE_N   = 16,
   parameter logic [N-1:0]    VPP_MIN    = N'(10),
   parameter logic [7:0]      MA_MIN     = 8'd5,
   parameter logic [12:0]     FOFF_MIN   = 13'd50
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sample_en,
   input  logic        restart,
   input  logic        is_sine_wave,
   input  logic [15:0] freq_out,
   input  logic [N-1:0] vpp,
   input  logic [7:0]  ma,
   input  logic [7:0]  mf,
   input  logic [12:0] f_offset_max,
   output logic [2:0]  mod_type,
   output logic        mod_valid,
   output logic [15:0] freq_avg,
   output logic [7:0]  ma_out,
   output logic [7:0]  mf_out,
   output logic        ma_measure_enable,
   output logic        mf_measure_enable
);

   localparam int SETTLE_W = (SETTLE_CNT > 1) ? $clog2(SETTLE_CNT) : 1;
   localparam int RUN_W    = $clog2(STABLE_N + 1);

   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CNT - 1);
   localparam logic [RUN_W-1:0]    RUN_TERM    = RUN_W'(STABLE_N);
   localparam logic [RUN_W-1:0]    RUN_ONE     = RUN_W'(1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [1:0]          r_state;
   logic [SETTLE_W-1:0] r_settle_cnt;
   logic [RUN_W-1:0]    r_run;
   logic [RUN_W-1:0]    r_miss;
   logic [2:0]          r_prev;
   logic [2:0]          r_mod_type;
   logic [7:0]          r_ma_out;
   logic [7:0]          r_mf_out;
   logic                r_mod_valid;
   logic                r_ma_en;
   logic                r_mf_en;

   logic [2:0]          w_cand;
   logic [RUN_W-1:0]    w_run_next;
   logic [RUN_W-1:0]    w_miss_next;

   // ---------------------------------------------------------------------
   // Per-sample candidate and debounce counters
   // ---------------------------------------------------------------------
   assign w_cand = classify(vpp < VPP_MIN,
                            is_sine_wave,
                            ma >= MA_MIN,
                            f_offset_max >= FOFF_MIN);

   // Run of identical candidates while confirming; a new candidate starts
   // a fresh run of length one.
   assign w_run_next = (w_cand != r_prev)     ? RUN_ONE  :
                       (r_run == RUN_TERM)    ? RUN_TERM :
                                                r_run + 1'b1;

   // Consecutive strobes disagreeing with the locked type.
   assign w_miss_next = (w_cand == r_mod_type) ? '0       :
                        (r_miss == RUN_TERM)   ? RUN_TERM :
                                                 r_miss + 1'b1;

   // ---------------------------------------------------------------------
   // Settle / confirm / lock FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_SETTLE;
         r_settle_cnt <= '0;
         r_run        <= '0;
         r_miss       <= '0;
         r_prev       <= MOD_NONE;
         r_mod_type   <= MOD_NONE;
         r_ma_out     <= '0;
         r_mf_out     <= '0;
      end else if (restart) begin
         // Restart overrides any coincident strobe; the reported type and
         // captured metrics are held until the next lock.
         r_state      <= ST_SETTLE;
         r_settle_cnt <= '0;
         r_run        <= '0;
         r_miss       <= '0;
      end else if (sample_en) begin
         case (r_state)
            ST_SETTLE: begin
               if (r_settle_cnt == SETTLE_LAST) begin
                  r_state <= ST_CONFIRM;
                  r_run   <= '0;
               end else begin
                  r_settle_cnt <= r_settle_cnt + 1'b1;
               end
            end

            ST_CONFIRM: begin
               r_run  <= w_run_next;
               r_prev <= w_cand;
               if (w_run_next == RUN_TERM) begin
                  r_state    <= ST_LOCKED;
                  r_mod_type <= w_cand;
                  r_ma_out   <= ma;
                  r_mf_out   <= mf;
                  r_miss     <= '0;
               end
            end

            ST_LOCKED: begin
               // A long enough disagreement re-locks in place on the
               // current candidate rather than dropping back to CONFIRM.
               if (w_miss_next == RUN_TERM) begin
                  r_mod_type <= w_cand;
                  r_ma_out   <= ma;
                  r_mf_out   <= mf;
                  r_miss     <= '0;
               end else begin
                  r_miss <= w_miss_next;
               end
            end

            default: begin
               r_state <= ST_SETTLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Registered status / enables, one clock behind the FSM state
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mod_valid <= 1'b0;
         r_ma_en     <= 1'b0;
         r_mf_en     <= 1'b0;
      end else begin
         r_mod_valid <= (r_state == ST_LOCKED);
         r_ma_en     <= (r_state == ST_CONFIRM) ||
                        ((r_state == ST_LOCKED) && (r_mod_type == MOD_AM));
         r_mf_en     <= (r_state == ST_CONFIRM) ||
                        ((r_state == ST_LOCKED) && (r_mod_type == MOD_FM));
      end
   end

   // ---------------------------------------------------------------------
   // Frequency block average
   // ---------------------------------------------------------------------
   freq_block_avg u_freq_avg (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_strobe   (sample_en),
      .i_clear    (restart),
      .i_freq     (freq_out),
      .o_freq_avg (freq_avg)
   );

   assign mod_type          = r_mod_type;
   assign mod_valid         = r_mod_valid;
   assign ma_out            = r_ma_out;
   assign mf_out            = r_mf_out;
   assign ma_measure_enable = r_ma_en;
   assign mf_measure_enable = r_mf_en;

endmodule : mod_classifier
`default_nettype wire

// File: tb/tb_mod_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_classifier
//  Purpose  : Self-checking bench for mod_classifier. A behavioural model
//             tracks the expected outputs from the classification and
//             debounce rules; directed scenarios pin key values literally and
//             a randomized phase exercises the rest.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mod_classifier;

   localparam int SETTLE = 400;
   localparam int STABLE = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_en = 1'b0;
   logic        restart = 1'b0;
   logic        is_sine_wave = 1'b1;
   logic [15:0] freq_out = '0;
   logic [7:0]  vpp = '0;
   logic [7:0]  ma = '0;
   logic [7:0]  mf = '0;
   logic [12:0] f_offset_max = '0;

   logic [2:0]  mod_type;
   logic        mod_valid;
   logic [15:0] freq_avg;
   logic [7:0]  ma_out;
   logic [7:0]  mf_out;
   logic        ma_measure_enable;
   logic        mf_measure_enable;

   mod_classifier dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .sample_en         (sample_en),
      .restart           (restart),
      .is_sine_wave      (is_sine_wave),
      .freq_out          (freq_out),
      .vpp               (vpp),
      .ma                (ma),
      .mf                (mf),
      .f_offset_max      (f_offset_max),
      .mod_type          (mod_type),
      .mod_valid         (mod_valid),
      .freq_avg          (freq_avg),
      .ma_out            (ma_out),
      .mf_out            (mf_out),
      .ma_measure_enable (ma_measure_enable),
      .mf_measure_enable (mf_measure_enable)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit valid_seen = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model
   // ---------------------------------------------------------------------
   function automatic int classify_ref(bit sine, int v, int a, int fo);
      if (v < 10)  return 0;   // NONE
      if (!sine)   return 4;   // DIGITAL
      if (a >= 5)  return 2;   // AM
      if (fo >= 50) return 3;  // FM
      return 1;                // CW
   endfunction

   bit m_settled, m_locked;
   int m_seen, m_streak, m_last, m_miss;
   int blk_sum, blk_n;
   int e_type, e_ma, e_mf, e_favg;
   bit e_valid, e_maen, e_mfen;

   task automatic model_step();
      bit nv, nma, nmf;
      int cand;
      if (!rst_n) begin
         m_settled = 0; m_locked = 0; m_seen = 0; m_streak = 0; m_last = 0; m_miss = 0;
         blk_sum = 0; blk_n = 0;
         e_type = 0; e_ma = 0; e_mf = 0; e_favg = 0;
         e_valid = 0; e_maen = 0; e_mfen = 0;
      end else begin
         // status outputs reflect the situation before this edge
         nv  = m_locked;
         nma = m_settled && (!m_locked || e_type == 2);
         nmf = m_settled && (!m_locked || e_type == 3);
         if (restart) begin
            m_settled = 0; m_locked = 0; m_seen = 0; m_streak = 0; m_miss = 0;
            blk_sum = 0; blk_n = 0;
         end else if (sample_en) begin
            cand = classify_ref(is_sine_wave, int'(vpp), int'(ma), int'(f_offset_max));
            blk_sum += int'(freq_out);
            blk_n++;
            if (blk_n == 8) begin
               e_favg = blk_sum / 8;
               blk_sum = 0; blk_n = 0;
            end
            if (!m_settled) begin
               m_seen++;
               if (m_seen == SETTLE) m_settled = 1;
               m_streak = 0;
            end else if (!m_locked) begin
               if (m_streak > 0 && cand == m_last) m_streak++;
               else m_streak = 1;
               m_last = cand;
               if (m_streak == STABLE) begin
                  m_locked = 1; e_type = cand; e_ma = int'(ma); e_mf = int'(mf); m_miss = 0;
               end
            end else begin
               if (cand != e_type) m_miss++;
               else m_miss = 0;
               if (m_miss == STABLE) begin
                  e_type = cand; e_ma = int'(ma); e_mf = int'(mf); m_miss = 0;
               end
            end
         end
         e_valid = nv; e_maen = nma; e_mfen = nmf;
      end
   endtask

   initial begin
      model_step();
      forever begin
         @(posedge clk or negedge rst_n);
         model_step();
      end
   end

   // Compare process: outputs are meaningful every cycle.
   initial begin
      forever begin
         @(negedge clk);
         check("mod_type",  mod_type,          e_type);
         check("mod_valid", mod_valid,         e_valid);
         check("freq_avg",  freq_avg,          e_favg);
         check("ma_out",    ma_out,            e_ma);
         check("mf_out",    mf_out,            e_mf);
         check("ma_en",     ma_measure_enable, e_maen);
         check("mf_en",     mf_measure_enable, e_mfen);
         if (mod_valid === 1'b1) valid_seen = 1;
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers (called at a negedge, return at a negedge)
   // ---------------------------------------------------------------------
   task automatic strobe(input bit sine, input int f, input int v, input int a,
                         input int m, input int fo);
      is_sine_wave = sine;
      freq_out     = 16'(f);
      vpp          = 8'(v);
      ma           = 8'(a);
      mf           = 8'(m);
      f_offset_max = 13'(fo);
      sample_en    = 1'b1;
      @(negedge clk);
      sample_en    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
   endtask

   task automatic pulse_restart(input bit with_strobe);
      restart   = 1'b1;
      sample_en = with_strobe;
      @(negedge clk);
      restart   = 1'b0;
      sample_en = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------
   int len, kind, v, a, fo, mm;
   bit sn;

   initial begin
      @(negedge clk);
      do_reset();
      check("rst_mod_valid", mod_valid, 0);
      check("rst_freq_avg", freq_avg, 0);

      // Frequency block averaging
      for (int k = 0; k < 8; k++) strobe(1, 1000 + 8 * k, 100, 0, 0, 0);
      check("favg_ramp", freq_avg, 1028);
      for (int k = 0; k < 8; k++) strobe(1, 65535, 100, 0, 0, 0);
      check("favg_full", freq_avg, 65535);

      // Lock on AM
      do_reset();
      for (int k = 0; k < SETTLE + STABLE; k++) strobe(1, 5000, 100, 20, 0, 0);
      check("am_type", mod_type, 2);
      check("am_ma_out", ma_out, 20);
      idle(1);
      check("am_valid", mod_valid, 1);
      check("am_ma_en", ma_measure_enable, 1);
      check("am_mf_en", mf_measure_enable, 0);

      // 15 FM candidates then one AM keeps AM; 16 FM relock
      for (int k = 0; k < STABLE - 1; k++) strobe(1, 5000, 100, 0, 7, 100);
      strobe(1, 5000, 100, 20, 7, 100);
      check("am_hold", mod_type, 2);
      for (int k = 0; k < STABLE; k++) strobe(1, 5000, 100, 0, 7, 100);
      check("fm_type", mod_type, 3);
      check("fm_mf_out", mf_out, 7);
      idle(1);
      check("fm_valid", mod_valid, 1);
      check("fm_mf_en", mf_measure_enable, 1);

      // Restart coincident with a strobe while locked
      pulse_restart(1'b1);
      idle(1);
      check("rs_valid", mod_valid, 0);
      check("rs_ma_en", ma_measure_enable, 0);
      check("rs_type_held", mod_type, 3);
      for (int k = 0; k < SETTLE - 1; k++) strobe(1, 3000, 100, 0, 0, 0);
      idle(1);
      check("rs_settling", ma_measure_enable, 0);
      strobe(1, 3000, 100, 0, 0, 0);
      idle(1);
      check("rs_confirm_ma", ma_measure_enable, 1);
      check("rs_confirm_mf", mf_measure_enable, 1);

      // Alternating CW/NONE never locks
      do_reset();
      for (int k = 0; k < SETTLE; k++) strobe(1, 2000, 100, 0, 0, 0);
      valid_seen = 0;
      for (int k = 0; k < 100; k++) strobe(1, 2000, (k % 2) ? 5 : 100, 0, 0, 0);
      idle(1);
      check("alt_no_lock", valid_seen, 0);

      // DIGITAL, then low amplitude -> NONE
      do_reset();
      for (int k = 0; k < SETTLE + STABLE; k++) strobe(0, 4000, 200, 0, 0, 0);
      check("dig_type", mod_type, 4);
      for (int k = 0; k < STABLE; k++) strobe(0, 4000, 5, 30, 0, 0);
      check("none_type", mod_type, 0);
      idle(1);
      check("none_valid", mod_valid, 1);

      // Async reset mid-CONFIRM
      do_reset();
      for (int k = 0; k < SETTLE + 5; k++) strobe(1, 9000, 100, 0, 3, 0);
      idle(1);
      check("mid_conf_en", ma_measure_enable, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_type", mod_type, 0);
      check("arst_favg", freq_avg, 0);
      check("arst_ma_en", ma_measure_enable, 0);
      check("arst_mf_en", mf_measure_enable, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      // Randomized phase
      for (int blk = 0; blk < 150; blk++) begin
         len  = int'($urandom_range(4, 40));
         kind = int'($urandom_range(0, 4));
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            if ($urandom_range(0, 499) == 0) pulse_restart(1'($urandom_range(0, 1)));
            sn = 1; v = int'($urandom_range(10, 255));
            a = int'($urandom_range(0, 4)); fo = int'($urandom_range(0, 49));
            mm = int'($urandom_range(0, 255));
            case (($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : kind)
               0: begin v = int'($urandom_range(0, 9)); sn = 1'($urandom_range(0, 1));
                        a = int'($urandom_range(0, 255)); end
               1: sn = 0;
               2: a = int'($urandom_range(5, 255));
               3: fo = int'($urandom_range(50, 8191));
               default: ;
            endcase
            strobe(sn, int'($urandom_range(0, 65535)), v, a, mm, fo);
         end
      end
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_mod_classifier
`default_nettype wire
